// File: rtl/cobertura_ctrl_if.sv
// Sensor/valve bundle between the roof-cover pins and cobertura_ctrl.
// master drives the raw sensors and clear request; slave drives valves and status.
interface cobertura_ctrl_if;
  logic       L;
  logic       U;
  logic       Fd;
  logic       Fe;
  logic       clr;
  logic       A;
  logic       F;
  logic       fault;
  logic [2:0] state;

  modport master (
    output L, U, Fd, Fe, clr,
    input  A, F, fault, state
  );

  modport slave (
    input  L, U, Fd, Fe, clr,
    output A, F, fault, state
  );
endinterface

// File: rtl/cobertura_ctrl.sv
// Roof-cover valve controller: debounced sensors, open/close FSM with reversal
// dead time, run-time limit and latched fault.
module cobertura_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int DEAD_CYCLES = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  cobertura_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPENING = 3'd1,
    CLOSING = 3'd2,
    DEAD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + DEAD_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYCLES - 1);

  // Bit order: 0 L, 1 U, 2 Fd, 3 Fe
  logic [3:0]    raw_s;
  logic [3:0]    deb_r;
  logic [CW-1:0] deb_cnt_r [4];

  state_t        state_r;
  state_t        next_s;
  logic [TW-1:0] timer_r;
  logic          a_r;
  logic          f_r;
  logic          fault_r;

  logic close_req_s;
  logic open_req_s;
  logic limit_err_s;
  logic active_s;

  assign raw_s = {bus.Fe, bus.Fd, bus.U, bus.L};

  // Per-input debounce: a change must persist DEB_CYCLES edges to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raw_s[i] == deb_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_r[i]     <= raw_s[i];
          deb_cnt_r[i] <= '0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign close_req_s = deb_r[0] | deb_r[1];
  assign open_req_s  = ~deb_r[0] & ~deb_r[1];
  assign limit_err_s = deb_r[2] & deb_r[3];
  assign active_s    = (state_r == OPENING) || (state_r == CLOSING) || (state_r == DEAD);

  // Next-state decode; limit error always takes precedence
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (limit_err_s)                    next_s = FAULT;
        else if (close_req_s && !deb_r[3])  next_s = CLOSING;
        else if (open_req_s && !deb_r[2])   next_s = OPENING;
        else                                next_s = IDLE;
      end
      OPENING: begin
        if (limit_err_s)             next_s = FAULT;
        else if (deb_r[2])           next_s = IDLE;
        else if (close_req_s)        next_s = DEAD;
        else if (timer_r == TO_LAST) next_s = FAULT;
        else                         next_s = OPENING;
      end
      CLOSING: begin
        // Open request deliberately ignored here to avoid hunting
        if (limit_err_s)             next_s = FAULT;
        else if (deb_r[3])           next_s = IDLE;
        else if (timer_r == TO_LAST) next_s = FAULT;
        else                         next_s = CLOSING;
      end
      DEAD: begin
        if (limit_err_s)               next_s = FAULT;
        else if (timer_r == DEAD_LAST) next_s = deb_r[3] ? IDLE : CLOSING;
        else                           next_s = DEAD;
      end
      FAULT: begin
        if (bus.clr && !limit_err_s) next_s = IDLE;
        else                         next_s = FAULT;
      end
      default: next_s = FAULT;
    endcase
  end

  // State register, dwell timer and registered output decode of next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= '0;
      a_r     <= 1'b0;
      f_r     <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= next_s;
      if (next_s != state_r) begin
        timer_r <= '0;
      end else if (active_s) begin
        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        timer_r <= timer_r;
      end
      a_r     <= (next_s == OPENING);
      f_r     <= (next_s == CLOSING);
      fault_r <= (next_s == FAULT);
    end
  end

  assign bus.A     = a_r;
  assign bus.F     = f_r;
  assign bus.fault = fault_r;
  assign bus.state = state_r;

endmodule

// File: tb/tb_cobertura_ctrl.sv
// Directed bench for cobertura_ctrl: per-edge comparison against a behavioural
// model of the cover controller plus hand-computed checkpoints.
module tb_cobertura_ctrl;

  localparam int DEB  = 4;
  localparam int DEAD = 8;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic rst;
  cobertura_ctrl_if bus();

  cobertura_ctrl #(.DEB_CYCLES(DEB), .DEAD_CYCLES(DEAD), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: filtered sensor view, state number and cycles spent in that state
  int m_deb [4];
  int m_run [4];
  int m_state;
  int m_age;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int raw [4];
    int nxt;
    int spent;
    raw[0] = int'(bus.L);  raw[1] = int'(bus.U);
    raw[2] = int'(bus.Fd); raw[3] = int'(bus.Fe);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_deb[i] = 0; m_run[i] = 0; end
      m_state = 0;
      m_age   = 0;
    end else begin
      spent = m_age + 1;
      nxt = m_state;
      if (m_deb[2] == 1 && m_deb[3] == 1 && m_state != 4) nxt = 4;
      else if (m_state == 0) begin
        if ((m_deb[0] | m_deb[1]) == 1 && m_deb[3] == 0) nxt = 2;
        else if (m_deb[0] == 0 && m_deb[1] == 0 && m_deb[2] == 0) nxt = 1;
      end else if (m_state == 1) begin
        if (m_deb[2] == 1) nxt = 0;
        else if ((m_deb[0] | m_deb[1]) == 1) nxt = 3;
        else if (spent == TO) nxt = 4;
      end else if (m_state == 2) begin
        if (m_deb[3] == 1) nxt = 0;
        else if (spent == TO) nxt = 4;
      end else if (m_state == 3) begin
        if (spent == DEAD) nxt = (m_deb[3] == 1) ? 0 : 2;
      end else begin
        if (bus.clr && !(m_deb[2] == 1 && m_deb[3] == 1)) nxt = 0;
      end
      m_age   = (nxt != m_state) ? 0 : m_age + 1;
      m_state = nxt;
      for (int i = 0; i < 4; i++) begin
        if (raw[i] == m_deb[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_deb[i] = raw[i]; m_run[i] = 0; end
        end
      end
    end
  endtask

  // One clock edge: advance the model, then compare all outputs just after the edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("state", int'(bus.state), m_state);
    check("A",     int'(bus.A),     (m_state == 1) ? 1 : 0);
    check("F",     int'(bus.F),     (m_state == 2) ? 1 : 0);
    check("fault", int'(bus.fault), (m_state == 4) ? 1 : 0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.L = 1'b0; bus.U = 1'b0; bus.Fd = 1'b0; bus.Fe = 1'b0; bus.clr = 1'b0;
    ticks(2);
    check("rst_state", int'(bus.state), 0);
    check("rst_A", int'(bus.A), 0);
    check("rst_F", int'(bus.F), 0);
    check("rst_fault", int'(bus.fault), 0);

    // Open on first edge, stop at open limit after DEB+1 edges
    rst = 1'b0;
    tick();
    check("t1_open_A", int'(bus.A), 1);
    check("t1_open_state", int'(bus.state), 1);
    bus.Fd = 1'b1;
    ticks(4);
    check("t1_still_open", int'(bus.state), 1);
    tick();
    check("t1_limit_state", int'(bus.state), 0);
    check("t1_limit_A", int'(bus.A), 0);
    bus.Fd = 1'b0;
    ticks(5);
    check("t1_reopen", int'(bus.A), 1);

    // Rain while opening: dead time, then closing, stop at closed limit
    bus.U = 1'b1;
    ticks(4);
    check("t2_pre_dead", int'(bus.A), 1);
    tick();
    check("t2_dead_A", int'(bus.A), 0);
    check("t2_dead_state", int'(bus.state), 3);
    ticks(7);
    check("t2_dead_hold_F", int'(bus.F), 0);
    tick();
    check("t2_close_F", int'(bus.F), 1);
    check("t2_close_state", int'(bus.state), 2);
    bus.Fe = 1'b1;
    ticks(5);
    check("t2_closed_F", int'(bus.F), 0);
    check("t2_closed_state", int'(bus.state), 0);
    bus.U = 1'b0; bus.Fe = 1'b0;
    ticks(5);
    check("t2_reopen_state", int'(bus.state), 1);

    // Short rain glitch is filtered out
    bus.U = 1'b1;
    ticks(3);
    bus.U = 1'b0;
    ticks(5);
    check("t3_glitch_A", int'(bus.A), 1);
    check("t3_glitch_state", int'(bus.state), 1);

    // Run-time limit: A high for exactly TO cycles, then latched fault
    ticks(55);
    check("t4_last_open_A", int'(bus.A), 1);
    tick();
    check("t4_to_A", int'(bus.A), 0);
    check("t4_to_fault", int'(bus.fault), 1);
    check("t4_to_state", int'(bus.state), 4);
    ticks(10);
    check("t4_hold_state", int'(bus.state), 4);
    bus.clr = 1'b1;
    tick();
    check("t4_clr_state", int'(bus.state), 0);
    bus.clr = 1'b0;
    tick();
    check("t4_reopen", int'(bus.state), 1);

    // Both limits active: fault that clr cannot clear until the error goes
    bus.Fd = 1'b1;
    ticks(5);
    check("t5_idle", int'(bus.state), 0);
    bus.Fe = 1'b1;
    ticks(4);
    check("t5_pre_fault", int'(bus.state), 0);
    tick();
    check("t5_fault", int'(bus.state), 4);
    bus.clr = 1'b1;
    ticks(2);
    check("t5_clr_blocked", int'(bus.state), 4);
    bus.clr = 1'b0; bus.Fe = 1'b0;
    ticks(5);
    check("t5_still_fault", int'(bus.state), 4);
    bus.clr = 1'b1;
    tick();
    check("t5_clr_ok", int'(bus.state), 0);
    bus.clr = 1'b0;
    ticks(2);

    // Reset mid-closing, then debouncers restart from zero
    bus.Fd = 1'b0; bus.L = 1'b1;
    ticks(5);
    check("t6_closing_F", int'(bus.F), 1);
    ticks(3);
    rst = 1'b1;
    tick();
    check("t6_rst_F", int'(bus.F), 0);
    check("t6_rst_state", int'(bus.state), 0);
    check("t6_rst_fault", int'(bus.fault), 0);
    rst = 1'b0;
    tick();
    check("t6_restart_A", int'(bus.A), 1);
    ticks(3);
    check("t6_restart_hold", int'(bus.state), 1);
    tick();
    check("t6_dead", int'(bus.state), 3);
    ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
